// File: rtl/crc_stream_engine_pkg.sv
// Shared CRC constants, frame FSM state type and bit-reverse helper
// used by the streaming CRC engine and its bench.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Reverses the low w bits of v; bits above w come back as zero.
  function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
    logic [63:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        idx  = 6'(w - 1 - i);
        r[i] = v[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// Combinational CRC fold: applies DATA_W message bits to the remainder
// in one step, LSB first when REFLECT_IN is set, MSB first otherwise.
module crc_step #(
  parameter int               CRC_W      = 32,
  parameter int               DATA_W     = 8,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(32'h04C11DB7),
  parameter bit               REFLECT_IN = 1'b1
) (
  input  logic [CRC_W-1:0]  rem,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  next_rem
);

  always_comb begin
    next_rem = rem;
    for (int i = 0; i < DATA_W; i++) begin
      if (((REFLECT_IN ? data[i] : data[DATA_W-1-i]) ^ next_rem[CRC_W-1]) == 1'b1)
        next_rem = {next_rem[CRC_W-2:0], 1'b0} ^ POLY;
      else
        next_rem = {next_rem[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed streaming CRC engine: folds one beat per clock, reports the
// finished CRC and residue match in a one-cycle DONE slot after the last beat.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W       = 32,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(CRC32_POLY),
  parameter logic [CRC_W-1:0] INIT        = {CRC_W{1'b1}},
  parameter logic [CRC_W-1:0] XOR_OUT     = {CRC_W{1'b1}},
  parameter int               DATA_W      = 8,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [CRC_W-1:0] RESIDUE     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_match,
  output logic              busy
);

  state_t           state;
  logic [CRC_W-1:0] rem;
  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] next_rem;
  logic [CRC_W-1:0] finished;
  logic             accept;
  logic             last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && in_last;
  // A beat arriving with start belongs to the new frame, so fold it against INIT.
  assign base      = start ? INIT : rem;

  crc_step #(
    .CRC_W      (CRC_W),
    .DATA_W     (DATA_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .rem      (base),
    .data     (in_data),
    .next_rem (next_rem)
  );

  assign finished = (REFLECT_OUT ? CRC_W'(bitrev(64'(next_rem), CRC_W)) : next_rem) ^ XOR_OUT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= INIT;
      in_ready  <= 1'b1;
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_match <= 1'b0;
      busy      <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (start) begin
        crc_out   <= '0;
        crc_match <= 1'b0;
      end
      if (last_beat) begin
        state     <= DONE;
        rem       <= INIT;
        in_ready  <= 1'b0;
        crc_valid <= 1'b1;
        crc_out   <= finished;
        crc_match <= (next_rem == RESIDUE);
        busy      <= 1'b0;
      end else if (accept) begin
        state <= RUN;
        rem   <= next_rem;
        busy  <= 1'b1;
      end else if (start) begin
        state    <= IDLE;
        rem      <= INIT;
        busy     <= 1'b0;
        in_ready <= 1'b1;
      end else if (state == DONE) begin
        state    <= IDLE;
        in_ready <= 1'b1;
      end
    end
  end

endmodule
